// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : instruction-decode stage of a 5-stage MIPS pipeline.
//
// Holds the 32x32 register file, decodes the current instruction, resolves
// beq/bne/j in this stage, detects load-use and branch-operand hazards and
// registers the decoded instruction into the ID/EX pipeline register.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   if_inst, if_pc4          instruction from fetch (0 = bubble) and its PC+1
//   ex_wreg, ex_m2reg, ex_rd EX-stage write enable / is-load / destination
//   mem_wreg, mem_rd         MEM-stage write enable / destination
//   wb_wreg, wb_rd, wb_data  register-file write port from WB
//   stall                    hold fetch PC and bubble the fetch output
//   ctrl_branch, nid_pc      taken branch and its target
//   id_jmp, id_jmp_pc        jump and its target
//   ex_*                     ID/EX pipeline register contents
// ---------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc4,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rd,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_rd,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ctrl_branch,
  output logic [31:0] nid_pc,
  output logic        id_jmp,
  output logic [31:0] id_jmp_pc,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_dst,
  output logic [3:0]  ex_aluc,
  output logic        ex_wreg_o,
  output logic        ex_m2reg_o,
  output logic        ex_wmem,
  output logic        ex_aluimm,
  output logic        ex_shift
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // ALU operation encoding carried in ex_aluc
  localparam logic [3:0] INST_TYPE_ADD = 4'd0;
  localparam logic [3:0] INST_TYPE_SUB = 4'd1;
  localparam logic [3:0] INST_TYPE_AND = 4'd2;
  localparam logic [3:0] INST_TYPE_OR  = 4'd3;
  localparam logic [3:0] INST_TYPE_NOR = 4'd4;
  localparam logic [3:0] INST_TYPE_SLT = 4'd5;
  localparam logic [3:0] INST_TYPE_SLL = 4'd6;
  localparam logic [3:0] INST_TYPE_SRL = 4'd7;
  localparam logic [3:0] INST_TYPE_SRA = 4'd8;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_REPLAY = 1'b1
  } hold_state_e;

  // Hold FSM state
  hold_state_e state_q, state_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  // Register file
  logic [31:0] rf_q [32];

  // Current instruction and its fields
  logic [31:0] cur_inst_s;
  logic [31:0] cur_pc4_s;
  logic [5:0]  op_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [5:0]  funct_s;
  logic [15:0] imm16_s;

  // R-type sub-decode
  logic        r_valid_s;
  logic        r_shift_s;
  logic [3:0]  r_aluc_s;

  // Decoded control
  logic        dec_wreg_s;
  logic        dec_m2reg_s;
  logic        dec_wmem_s;
  logic        dec_aluimm_s;
  logic        dec_shift_s;
  logic        dec_sext_s;
  logic        dec_dst_rt_s;
  logic        dec_use_rs_s;
  logic        dec_use_rt_s;
  logic        dec_beq_s;
  logic        dec_bne_s;
  logic        dec_j_s;
  logic [3:0]  dec_aluc_s;

  // Operands and hazard terms
  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;
  logic [31:0] imm_ext_s;
  logic [31:0] br_off_s;
  logic [4:0]  dst_s;
  logic        load_use_s;
  logic        br_dep_s;
  logic        stall_s;
  logic        ops_equal_s;

  // ID/EX pipeline register
  logic [31:0] ex_pc4_q, ex_a_q, ex_b_q, ex_imm_q;
  logic [4:0]  ex_shamt_q, ex_dst_q;
  logic [3:0]  ex_aluc_q;
  logic        ex_wreg_q, ex_m2reg_q, ex_wmem_q, ex_aluimm_q, ex_shift_q;

  // While replaying, fetch is presenting a bubble, so the held copy is used.
  assign cur_inst_s = (state_q == ST_REPLAY) ? hold_inst_q : if_inst;
  assign cur_pc4_s  = (state_q == ST_REPLAY) ? hold_pc4_q  : if_pc4;

  assign op_s    = cur_inst_s[31:26];
  assign rs_s    = cur_inst_s[25:21];
  assign rt_s    = cur_inst_s[20:16];
  assign rd_s    = cur_inst_s[15:11];
  assign shamt_s = cur_inst_s[10:6];
  assign funct_s = cur_inst_s[5:0];
  assign imm16_s = cur_inst_s[15:0];

  // Register file write port; entry 0 is never written and stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (wb_wreg && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Combinational reads with a bypass of the write happening this cycle.
  assign rs_data_s = (rs_s == 5'd0) ? 32'd0 :
                     (wb_wreg && (wb_rd == rs_s)) ? wb_data : rf_q[rs_s];
  assign rt_data_s = (rt_s == 5'd0) ? 32'd0 :
                     (wb_wreg && (wb_rd == rt_s)) ? wb_data : rf_q[rt_s];

  // R-type function decode
  always_comb begin
    r_valid_s = 1'b1;
    r_shift_s = 1'b0;
    r_aluc_s  = INST_TYPE_ADD;
    case (funct_s)
      FN_ADD: r_aluc_s = INST_TYPE_ADD;
      FN_SUB: r_aluc_s = INST_TYPE_SUB;
      FN_AND: r_aluc_s = INST_TYPE_AND;
      FN_OR:  r_aluc_s = INST_TYPE_OR;
      FN_NOR: r_aluc_s = INST_TYPE_NOR;
      FN_SLT: r_aluc_s = INST_TYPE_SLT;
      FN_SLL: begin r_aluc_s = INST_TYPE_SLL; r_shift_s = 1'b1; end
      FN_SRL: begin r_aluc_s = INST_TYPE_SRL; r_shift_s = 1'b1; end
      FN_SRA: begin r_aluc_s = INST_TYPE_SRA; r_shift_s = 1'b1; end
      default: r_valid_s = 1'b0;
    endcase
  end

  // Main decoder; an all-zero word is a fetch bubble, not sll $0,$0,0.
  always_comb begin
    dec_wreg_s   = 1'b0;
    dec_m2reg_s  = 1'b0;
    dec_wmem_s   = 1'b0;
    dec_aluimm_s = 1'b0;
    dec_shift_s  = 1'b0;
    dec_sext_s   = 1'b1;
    dec_dst_rt_s = 1'b0;
    dec_use_rs_s = 1'b0;
    dec_use_rt_s = 1'b0;
    dec_beq_s    = 1'b0;
    dec_bne_s    = 1'b0;
    dec_j_s      = 1'b0;
    dec_aluc_s   = INST_TYPE_ADD;
    if (cur_inst_s == 32'd0) begin
      dec_wreg_s = 1'b0;
    end else begin
      case (op_s)
        OP_RTYPE: begin
          if (r_valid_s) begin
            dec_wreg_s   = 1'b1;
            dec_aluc_s   = r_aluc_s;
            dec_shift_s  = r_shift_s;
            dec_use_rt_s = 1'b1;
            // shifts take their amount from shamt, rs is not read
            dec_use_rs_s = ~r_shift_s;
          end else begin
            dec_wreg_s = 1'b0;
          end
        end
        OP_ADDI: begin
          dec_wreg_s = 1'b1; dec_aluimm_s = 1'b1; dec_dst_rt_s = 1'b1;
          dec_use_rs_s = 1'b1; dec_aluc_s = INST_TYPE_ADD;
        end
        OP_ANDI: begin
          dec_wreg_s = 1'b1; dec_aluimm_s = 1'b1; dec_dst_rt_s = 1'b1;
          dec_use_rs_s = 1'b1; dec_sext_s = 1'b0; dec_aluc_s = INST_TYPE_AND;
        end
        OP_ORI: begin
          dec_wreg_s = 1'b1; dec_aluimm_s = 1'b1; dec_dst_rt_s = 1'b1;
          dec_use_rs_s = 1'b1; dec_sext_s = 1'b0; dec_aluc_s = INST_TYPE_OR;
        end
        OP_LW: begin
          dec_wreg_s = 1'b1; dec_m2reg_s = 1'b1; dec_aluimm_s = 1'b1;
          dec_dst_rt_s = 1'b1; dec_use_rs_s = 1'b1; dec_aluc_s = INST_TYPE_ADD;
        end
        OP_SW: begin
          dec_wmem_s = 1'b1; dec_aluimm_s = 1'b1; dec_use_rs_s = 1'b1;
          dec_use_rt_s = 1'b1; dec_aluc_s = INST_TYPE_ADD;
        end
        OP_BEQ: begin
          dec_beq_s = 1'b1; dec_use_rs_s = 1'b1; dec_use_rt_s = 1'b1;
          dec_aluc_s = INST_TYPE_SUB;
        end
        OP_BNE: begin
          dec_bne_s = 1'b1; dec_use_rs_s = 1'b1; dec_use_rt_s = 1'b1;
          dec_aluc_s = INST_TYPE_SUB;
        end
        OP_J: begin
          dec_j_s = 1'b1;
        end
        default: begin
          dec_wreg_s = 1'b0;
        end
      endcase
    end
  end

  assign imm_ext_s = dec_sext_s ? {{16{imm16_s[15]}}, imm16_s} : {16'd0, imm16_s};
  assign br_off_s  = {{16{imm16_s[15]}}, imm16_s};
  assign dst_s     = dec_dst_rt_s ? rt_s : rd_s;

  // Load-use: the value is only available after MEM, one bubble is needed.
  assign load_use_s = ex_wreg && ex_m2reg && (ex_rd != 5'd0) &&
                      ((dec_use_rs_s && (rs_s == ex_rd)) ||
                       (dec_use_rt_s && (rt_s == ex_rd)));

  // Branches compare in ID, so any producer still in EX or MEM must finish.
  assign br_dep_s = (dec_beq_s || dec_bne_s) &&
                    ((ex_wreg && (ex_rd != 5'd0) &&
                      ((rs_s == ex_rd) || (rt_s == ex_rd))) ||
                     (mem_wreg && (mem_rd != 5'd0) &&
                      ((rs_s == mem_rd) || (rt_s == mem_rd))));

  assign stall_s     = load_use_s || br_dep_s;
  assign ops_equal_s = (rs_data_s == rt_data_s);

  assign stall       = stall_s;
  assign ctrl_branch = ((dec_beq_s && ops_equal_s) || (dec_bne_s && !ops_equal_s)) && !stall_s;
  assign nid_pc      = cur_pc4_s + br_off_s;
  assign id_jmp      = dec_j_s && !stall_s;
  assign id_jmp_pc   = {cur_pc4_s[31:26], cur_inst_s[25:0]};

  // Hold FSM state and held-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      hold_inst_q <= 32'd0;
      hold_pc4_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      hold_inst_q <= hold_inst_d;
      hold_pc4_q  <= hold_pc4_d;
    end
  end

  // Hold FSM next state: capture on the first stalled cycle, release when clear
  always_comb begin
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    hold_pc4_d  = hold_pc4_q;
    case (state_q)
      ST_NORMAL: begin
        if (stall_s) begin
          hold_inst_d = if_inst;
          hold_pc4_d  = if_pc4;
          state_d     = ST_REPLAY;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_REPLAY: begin
        if (stall_s) begin
          state_d = ST_REPLAY;
        end else begin
          state_d     = ST_NORMAL;
          hold_inst_d = 32'd0;
          hold_pc4_d  = 32'd0;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // ID/EX register; a stall turns the issued slot into a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc4_q    <= 32'd0;
      ex_a_q      <= 32'd0;
      ex_b_q      <= 32'd0;
      ex_imm_q    <= 32'd0;
      ex_shamt_q  <= 5'd0;
      ex_dst_q    <= 5'd0;
      ex_aluc_q   <= 4'd0;
      ex_wreg_q   <= 1'b0;
      ex_m2reg_q  <= 1'b0;
      ex_wmem_q   <= 1'b0;
      ex_aluimm_q <= 1'b0;
      ex_shift_q  <= 1'b0;
    end else begin
      ex_pc4_q    <= cur_pc4_s;
      ex_a_q      <= rs_data_s;
      ex_b_q      <= rt_data_s;
      ex_imm_q    <= imm_ext_s;
      ex_shamt_q  <= shamt_s;
      ex_dst_q    <= dst_s;
      ex_aluc_q   <= dec_aluc_s;
      ex_aluimm_q <= dec_aluimm_s;
      ex_shift_q  <= dec_shift_s;
      ex_wreg_q   <= dec_wreg_s  && !stall_s;
      ex_m2reg_q  <= dec_m2reg_s && !stall_s;
      ex_wmem_q   <= dec_wmem_s  && !stall_s;
    end
  end

  assign ex_pc4     = ex_pc4_q;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_imm     = ex_imm_q;
  assign ex_shamt   = ex_shamt_q;
  assign ex_dst     = ex_dst_q;
  assign ex_aluc    = ex_aluc_q;
  assign ex_wreg_o  = ex_wreg_q;
  assign ex_m2reg_o = ex_m2reg_q;
  assign ex_wmem    = ex_wmem_q;
  assign ex_aluimm  = ex_aluimm_q;
  assign ex_shift   = ex_shift_q;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage : directed bench for id_stage. The driver issues one vector per
// cycle and queues the hand-computed values expected this cycle (combinational
// outputs) or after the next edge (ID/EX register). A monitor on the falling
// edge pops due entries and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_inst, if_pc4;
  logic        ex_wreg, ex_m2reg;
  logic [4:0]  ex_rd;
  logic        mem_wreg;
  logic [4:0]  mem_rd;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, ctrl_branch, id_jmp;
  logic [31:0] nid_pc, id_jmp_pc;
  logic [31:0] ex_pc4, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_shamt, ex_dst;
  logic [3:0]  ex_aluc;
  logic        ex_wreg_o, ex_m2reg_o, ex_wmem, ex_aluimm, ex_shift;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc4(if_pc4),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .mem_wreg(mem_wreg), .mem_rd(mem_rd),
    .wb_wreg(wb_wreg), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .ctrl_branch(ctrl_branch), .nid_pc(nid_pc),
    .id_jmp(id_jmp), .id_jmp_pc(id_jmp_pc),
    .ex_pc4(ex_pc4), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_shamt(ex_shamt), .ex_dst(ex_dst), .ex_aluc(ex_aluc),
    .ex_wreg_o(ex_wreg_o), .ex_m2reg_o(ex_m2reg_o), .ex_wmem(ex_wmem),
    .ex_aluimm(ex_aluimm), .ex_shift(ex_shift)
  );

  // ALU op encoding expected on ex_aluc
  localparam logic [31:0] ALU_ADD = 32'd0;
  localparam logic [31:0] ALU_SUB = 32'd1;
  localparam logic [31:0] ALU_OR  = 32'd3;
  localparam logic [31:0] ALU_SLL = 32'd6;

  localparam int S_STALL = 0,  S_BR = 1,     S_NID = 2,    S_JMP = 3,  S_JPC = 4;
  localparam int S_PC4 = 5,    S_A = 6,      S_B = 7,      S_IMM = 8,  S_SHAMT = 9;
  localparam int S_DST = 10,   S_ALUC = 11,  S_WREG = 12,  S_M2REG = 13;
  localparam int S_WMEM = 14,  S_ALUIMM = 15, S_SHIFT = 16;

  typedef struct {
    int          cyc;
    int          step;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   step = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_STALL:  return {31'd0, stall};
      S_BR:     return {31'd0, ctrl_branch};
      S_NID:    return nid_pc;
      S_JMP:    return {31'd0, id_jmp};
      S_JPC:    return id_jmp_pc;
      S_PC4:    return ex_pc4;
      S_A:      return ex_a;
      S_B:      return ex_b;
      S_IMM:    return ex_imm;
      S_SHAMT:  return {27'd0, ex_shamt};
      S_DST:    return {27'd0, ex_dst};
      S_ALUC:   return {28'd0, ex_aluc};
      S_WREG:   return {31'd0, ex_wreg_o};
      S_M2REG:  return {31'd0, ex_m2reg_o};
      S_WMEM:   return {31'd0, ex_wmem};
      S_ALUIMM: return {31'd0, ex_aluimm};
      S_SHIFT:  return {31'd0, ex_shift};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_STALL:  return "stall";
      S_BR:     return "ctrl_branch";
      S_NID:    return "nid_pc";
      S_JMP:    return "id_jmp";
      S_JPC:    return "id_jmp_pc";
      S_PC4:    return "ex_pc4";
      S_A:      return "ex_a";
      S_B:      return "ex_b";
      S_IMM:    return "ex_imm";
      S_SHAMT:  return "ex_shamt";
      S_DST:    return "ex_dst";
      S_ALUC:   return "ex_aluc";
      S_WREG:   return "ex_wreg_o";
      S_M2REG:  return "ex_m2reg_o";
      S_WMEM:   return "ex_wmem";
      S_ALUIMM: return "ex_aluimm";
      S_SHIFT:  return "ex_shift";
      default:  return "unknown";
    endcase
  endfunction

  // Queue an expectation for this cycle (dly=0) or after the next edge (dly=1)
  task automatic push_exp(input int sig, input logic [31:0] v, input int dly);
    exp_t e;
    e.cyc  = cyc + dly;
    e.step = step;
    e.sig  = sig;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic chk(input int sig, input logic [31:0] v);
    push_exp(sig, v, 0);
  endtask

  task automatic chk_nx(input int sig, input logic [31:0] v);
    push_exp(sig, v, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step++;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc4);
    if_inst = inst;
    if_pc4  = pc4;
  endtask

  // Monitor: compare every expectation that has come due this cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      act = actual(e.sig);
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL step %0d %s: check missed its cycle (due %0d, now %0d)",
                 e.step, sig_name(e.sig), e.cyc, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL step %0d %s: got 0x%08h expected 0x%08h",
                 e.step, sig_name(e.sig), act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    if_inst = 32'd0; if_pc4 = 32'd0;
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rd = 5'd0;
    mem_wreg = 1'b0; mem_rd = 5'd0;
    wb_wreg = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

    // reset state
    tick();
    chk(S_STALL, 32'd0); chk(S_BR, 32'd0); chk(S_JMP, 32'd0);
    chk(S_WREG, 32'd0); chk(S_PC4, 32'd0); chk(S_A, 32'd0); chk(S_DST, 32'd0);

    // addi $1,$0,5
    tick(); rst = 1'b0; fetch(32'h2001_0005, 32'd1);
    chk(S_STALL, 32'd0);
    chk_nx(S_IMM, 32'd5); chk_nx(S_DST, 32'd1); chk_nx(S_WREG, 32'd1);
    chk_nx(S_ALUIMM, 32'd1); chk_nx(S_PC4, 32'd1); chk_nx(S_ALUC, ALU_ADD);
    chk_nx(S_M2REG, 32'd0);

    // add $3,$2,$2 while WB writes $2=7: both operands via bypass
    tick(); fetch(32'h0042_1820, 32'd2);
    wb_wreg = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
    chk_nx(S_A, 32'd7); chk_nx(S_B, 32'd7); chk_nx(S_DST, 32'd3);
    chk_nx(S_ALUIMM, 32'd0); chk_nx(S_WREG, 32'd1);

    // add $3,$0,$2 while WB writes $0: rs stays 0, rt from the file
    tick(); fetch(32'h0002_1820, 32'd3);
    wb_rd = 5'd0; wb_data = 32'h0000_DEAD;
    chk_nx(S_A, 32'd0); chk_nx(S_B, 32'd7); chk_nx(S_PC4, 32'd3);

    // or $6,$0,$0 reads $0 after the ignored write; WB writes $1=9
    tick(); fetch(32'h0000_3025, 32'd4);
    wb_rd = 5'd1; wb_data = 32'd9;
    chk_nx(S_A, 32'd0); chk_nx(S_B, 32'd0); chk_nx(S_ALUC, ALU_OR); chk_nx(S_DST, 32'd6);

    // load-use: sub $5,$4,$1 behind lw $4
    tick(); fetch(32'h0081_2822, 32'h20);
    wb_wreg = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd4;
    chk(S_STALL, 32'd1); chk(S_BR, 32'd0);
    chk_nx(S_WREG, 32'd0); chk_nx(S_M2REG, 32'd0); chk_nx(S_WMEM, 32'd0);

    // hazard gone, fetch bubble: held sub issues
    tick(); fetch(32'd0, 32'd0);
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rd = 5'd0;
    chk(S_STALL, 32'd0);
    chk_nx(S_ALUC, ALU_SUB); chk_nx(S_DST, 32'd5); chk_nx(S_WREG, 32'd1);
    chk_nx(S_PC4, 32'h20); chk_nx(S_A, 32'd0); chk_nx(S_B, 32'd9);

    // ori $7,$0,0xFFFF decoded from if_inst: zero extension
    tick(); fetch(32'h3407_FFFF, 32'h21);
    chk_nx(S_IMM, 32'h0000_FFFF); chk_nx(S_DST, 32'd7); chk_nx(S_ALUC, ALU_OR);
    chk_nx(S_ALUIMM, 32'd1); chk_nx(S_PC4, 32'h21);

    // lw $8,-4($1): sign extension; WB writes $2=9
    tick(); fetch(32'h8C28_FFFC, 32'h22);
    wb_wreg = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
    chk_nx(S_IMM, 32'hFFFF_FFFC); chk_nx(S_M2REG, 32'd1); chk_nx(S_WREG, 32'd1);
    chk_nx(S_DST, 32'd8); chk_nx(S_A, 32'd9);

    // sw $2,8($1)
    tick(); fetch(32'hAC22_0008, 32'h23);
    wb_wreg = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    chk_nx(S_WMEM, 32'd1); chk_nx(S_WREG, 32'd0); chk_nx(S_B, 32'd9); chk_nx(S_IMM, 32'd8);

    // beq $1,$2,+3 with $1=$2=9
    tick(); fetch(32'h1022_0003, 32'h10);
    chk(S_BR, 32'd1); chk(S_NID, 32'h13); chk(S_STALL, 32'd0);
    chk_nx(S_WREG, 32'd0);

    // bne on the same values
    tick(); fetch(32'h1422_0003, 32'h10);
    chk(S_BR, 32'd0); chk(S_NID, 32'h13);

    // beq with a negative offset
    tick(); fetch(32'h1022_FFFE, 32'h10);
    chk(S_BR, 32'd1); chk(S_NID, 32'h0E);

    // beq with $1 produced in EX
    tick(); fetch(32'h1022_0003, 32'h10);
    ex_wreg = 1'b1; ex_rd = 5'd1;
    chk(S_STALL, 32'd1); chk(S_BR, 32'd0);
    chk_nx(S_WREG, 32'd0);

    // replaying, now $2 produced in MEM
    tick(); fetch(32'd0, 32'd0);
    ex_wreg = 1'b0; ex_rd = 5'd0; mem_wreg = 1'b1; mem_rd = 5'd2;
    chk(S_STALL, 32'd1); chk(S_BR, 32'd0);

    // released: held beq resolves; if_inst ignored while replaying
    tick(); fetch(32'h3407_FFFF, 32'h99);
    mem_wreg = 1'b0; mem_rd = 5'd0;
    chk(S_STALL, 32'd0); chk(S_BR, 32'd1); chk(S_NID, 32'h13);
    chk_nx(S_WREG, 32'd0); chk_nx(S_PC4, 32'h10);

    // j 0x40
    tick(); fetch(32'h0800_0040, 32'h0800_0001);
    chk(S_JMP, 32'd1); chk(S_JPC, 32'h0800_0040); chk(S_BR, 32'd0);
    chk_nx(S_WREG, 32'd0);

    // j with full target field and high PC bits
    tick(); fetch(32'h0BFF_FFFF, 32'hF000_0001);
    chk(S_JMP, 32'd1); chk(S_JPC, 32'hF3FF_FFFF);

    // sll $9,$2,4
    tick(); fetch(32'h0002_4900, 32'h30);
    chk(S_JMP, 32'd0);
    chk_nx(S_SHIFT, 32'd1); chk_nx(S_SHAMT, 32'd4); chk_nx(S_B, 32'd9);
    chk_nx(S_ALUC, ALU_SLL); chk_nx(S_DST, 32'd9); chk_nx(S_WREG, 32'd1);

    // unknown opcode decodes as NOP
    tick(); fetch(32'hFC00_0000, 32'h31);
    chk(S_STALL, 32'd0);
    chk_nx(S_WREG, 32'd0); chk_nx(S_WMEM, 32'd0); chk_nx(S_M2REG, 32'd0);

    // load-use stall to enter REPLAY
    tick(); fetch(32'h0081_2822, 32'h20);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd4;
    chk(S_STALL, 32'd1);
    chk_nx(S_WREG, 32'd0);

    // still stalled in REPLAY
    tick(); fetch(32'd0, 32'd0);
    chk(S_STALL, 32'd1);

    // reset mid-REPLAY: outputs clear at once, held sub discarded
    tick(); rst = 1'b1;
    chk(S_PC4, 32'd0); chk(S_DST, 32'd0); chk(S_WREG, 32'd0);
    chk(S_ALUC, 32'd0); chk(S_STALL, 32'd0);

    // add $10,$1,$2 after reset: decoded from if_inst, file cleared
    tick(); rst = 1'b0; fetch(32'h0022_5020, 32'h40);
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rd = 5'd0;
    chk(S_STALL, 32'd0);
    chk_nx(S_DST, 32'd10); chk_nx(S_PC4, 32'h40); chk_nx(S_A, 32'd0);
    chk_nx(S_B, 32'd0); chk_nx(S_ALUC, ALU_ADD); chk_nx(S_WREG, 32'd1);

    tick(); fetch(32'd0, 32'd0);
    tick();
    tick();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL step %0d %s: expectation never checked", sb[0].step, sig_name(sb[0].sig));
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
